// File: rtl/vga_timing_gen.sv
// VGA timing generator with test patterns: h/v sync, display enable,
// pixel position, start-of-frame strobe, frame counter and RGB pattern.
//
// Ports:
//   clk         system clock (all logic on this clock)
//   reset       asynchronous, active-high
//   enable      run the pixel-tick divider and counters; 0 freezes them
//   mode        0 solid, 1 colour bars, 2 checkerboard, 3 scrolling bars
//   solid_color {R,G,B} used in mode 0
//   h_sync      horizontal sync (active level SYNC_POL)
//   v_sync      vertical sync (active level SYNC_POL)
//   de          display enable
//   rgb         {R,G,B}, zero outside the visible area
//   pix_x       horizontal position of the current output pixel
//   pix_y       vertical position of the current output pixel
//   sof         one-clk pulse on the output update for position (0,0)
//   frame_cnt   frame counter, modulo 256
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int CLK_DIV   = 4,
  parameter int COLOR_W   = 1,
  parameter int BAR_W     = 80,
  parameter int TILE_LOG2 = 3,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_color,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 de,
  output logic [3*COLOR_W-1:0] rgb,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 sof,
  output logic [7:0]           frame_cnt
);

  localparam int   DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   BCW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic SP     = (SYNC_POL != 0);
  localparam int   HS_BEG = H_VISIBLE + H_FRONT;
  localparam int   HS_END = HS_BEG + H_SYNC;
  localparam int   VS_BEG = V_VISIBLE + V_FRONT;
  localparam int   VS_END = VS_BEG + V_SYNC;

  logic [DIV_W-1:0]     div_q, div_d;
  logic [XW-1:0]        h_q, h_d;
  logic [YW-1:0]        v_q, v_d;
  logic [7:0]           frm_q, frm_d;
  logic [2:0]           bar_q, bar_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [3*COLOR_W-1:0] sol_q, sol_d;

  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic                 de_q, de_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 sof_q, sof_d;

  logic                 tick;
  logic                 at00;
  logic                 h_wrap;
  logic                 v_wrap;
  logic                 vis;
  logic [1:0]           mode_e;
  logic [3*COLOR_W-1:0] sol_e;
  logic [2:0]           code;
  logic [3*COLOR_W-1:0] pat;

  always_comb begin
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    frm_d  = frm_q;
    bar_d  = bar_q;
    bcnt_d = bcnt_q;
    mode_d = mode_q;
    sol_d  = sol_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    de_d   = de_q;
    rgb_d  = rgb_q;
    x_d    = x_q;
    y_d    = y_q;
    sof_d  = 1'b0;
    tick   = 1'b0;
    code   = 3'd0;

    if (!enable) begin
      div_d = '0;
    end else if (int'(div_q) == CLK_DIV - 1) begin
      div_d = '0;
      tick  = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end

    at00   = (h_q == '0) && (v_q == '0);
    h_wrap = (int'(h_q) == H_TOTAL - 1);
    v_wrap = (int'(v_q) == V_TOTAL - 1);
    vis    = (int'(h_q) < H_VISIBLE) &&
             (int'(v_q) < V_VISIBLE);

    // The first pixel of a frame already uses the newly sampled mode.
    mode_e = at00 ? mode : mode_q;
    sol_e  = at00 ? solid_color : sol_q;

    unique case (mode_e)
      2'd0: code = 3'd0;
      2'd1: code = 3'd7 - bar_q;
      2'd2: code = (h_q[TILE_LOG2] ^ v_q[TILE_LOG2]) ?
                   3'd7 : 3'd0;
      2'd3: code = 3'd7 - (bar_q + frm_q[2:0]);
    endcase

    pat = (mode_e == 2'd0) ? sol_e :
          {{COLOR_W{code[2]}},
           {COLOR_W{code[1]}},
           {COLOR_W{code[0]}}};

    if (tick) begin
      if (at00) begin
        mode_d = mode;
        sol_d  = solid_color;
      end
      hs_d  = (int'(h_q) >= HS_BEG && int'(h_q) < HS_END) ?
              SP : ~SP;
      vs_d  = (int'(v_q) >= VS_BEG && int'(v_q) < VS_END) ?
              SP : ~SP;
      de_d  = vis;
      rgb_d = vis ? pat : '0;
      x_d   = h_q;
      y_d   = v_q;
      sof_d = at00;

      if (h_wrap) begin
        h_d    = '0;
        bar_d  = '0;
        bcnt_d = '0;
        if (v_wrap) begin
          v_d   = '0;
          frm_d = frm_q + 8'd1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
        if (int'(bcnt_q) == BAR_W - 1) begin
          bcnt_d = '0;
          if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      frm_q  <= '0;
      bar_q  <= '0;
      bcnt_q <= '0;
      mode_q <= '0;
      sol_q  <= '0;
      hs_q   <= ~SP;
      vs_q   <= ~SP;
      de_q   <= 1'b0;
      rgb_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      sof_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      frm_q  <= frm_d;
      bar_q  <= bar_d;
      bcnt_q <= bcnt_d;
      mode_q <= mode_d;
      sol_q  <= sol_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      rgb_q  <= rgb_d;
      x_q    <= x_d;
      y_q    <= y_d;
      sof_q  <= sof_d;
    end
  end

  assign h_sync    = hs_q;
  assign v_sync    = vs_q;
  assign de        = de_q;
  assign rgb       = rgb_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign sof       = sof_q;
  assign frame_cnt = frm_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 14x7 raster with CLK_DIV=2:
// every clk is scored against a queued model result, plus directed checks.
module tb_vga_timing_gen;

  localparam int HV  = 8;
  localparam int HF  = 2;
  localparam int HS  = 2;
  localparam int HB  = 2;
  localparam int VV  = 4;
  localparam int VF  = 1;
  localparam int VS  = 1;
  localparam int VB  = 1;
  localparam int HT  = 14;
  localparam int VT  = 7;
  localparam int DIV = 2;

  logic       clk = 0;
  logic       reset = 0;
  logic       enable = 0;
  logic [1:0] mode = 0;
  logic [2:0] solid_color = 3'b101;
  logic       h_sync;
  logic       v_sync;
  logic       de;
  logic [2:0] rgb;
  logic [3:0] pix_x;
  logic [2:0] pix_y;
  logic       sof;
  logic [7:0] frame_cnt;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0), .CLK_DIV(DIV), .COLOR_W(1),
    .BAR_W(1), .TILE_LOG2(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mode(mode), .solid_color(solid_color),
    .h_sync(h_sync), .v_sync(v_sync), .de(de), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y), .sof(sof),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [21:0] obs_t;
  localparam obs_t RST_V = {1'b1, 1'b1, 1'b0, 3'd0,
                            4'd0, 3'd0, 1'b0, 8'd0};

  obs_t       sb[$];
  obs_t       mexp;
  int         mh, mv, mdiv, mframe;
  logic [1:0] smode;
  logic [2:0] ssol;
  int         n_chk = 0;
  int         n_pass = 0;

  function automatic obs_t pk(logic hs_, logic vs_, logic de_,
                              logic [2:0] c, logic [3:0] x,
                              logic [2:0] y, logic s,
                              logic [7:0] f);
    return {hs_, vs_, de_, c, x, y, s, f};
  endfunction

  function automatic obs_t dut_obs();
    return {h_sync, v_sync, de, rgb, pix_x, pix_y, sof, frame_cnt};
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mdiv = 0; mframe = 0;
    smode = 0; ssol = 0;
    mexp = RST_V;
  endtask

  function automatic logic [2:0] model_code(int h, int v);
    int bar;
    bar = h / 1;
    if (bar > 7) bar = 7;
    case (smode)
      2'd0:    return ssol;
      2'd1:    return 3'(7 - bar);
      2'd2:    return (((h / 2) % 2) != ((v / 2) % 2)) ? 3'd7 : 3'd0;
      default: return 3'(7 - ((bar + mframe) % 8));
    endcase
  endfunction

  task automatic model_clk();
    logic dv;
    if (reset) begin
      model_reset();
      return;
    end
    mexp[8] = 1'b0;
    if (!enable) begin
      mdiv = 0;
      return;
    end
    if (mdiv != DIV - 1) begin
      mdiv++;
      return;
    end
    mdiv = 0;
    if (mh == 0 && mv == 0) begin
      smode = mode;
      ssol = solid_color;
    end
    dv = (mh < HV) && (mv < VV);
    mexp = pk(!(mh >= HV + HF && mh < HV + HF + HS),
              !(mv >= VV + VF && mv < VV + VF + VS),
              dv, dv ? model_code(mh, mv) : 3'd0,
              4'(mh), 3'(mv), (mh == 0 && mv == 0), 8'd0);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) begin
        mv = 0;
        mframe = (mframe + 1) % 256;
      end
    end
    mexp[7:0] = 8'(mframe);
  endtask

  task automatic clk_step();
    obs_t got;
    obs_t e;
    model_clk();
    sb.push_back(mexp);
    @(posedge clk);
    #1;
    got = dut_obs();
    e = sb.pop_front();
    n_chk++;
    assert (got === e) n_pass++;
    else $error("FAIL scoreboard got=%h exp=%h", got, e);
  endtask

  task automatic run_to_sof(input int budget, output int n);
    n = 0;
    do begin
      clk_step();
      n++;
    end while (sof !== 1'b1 && n < budget);
    chk("sof_seen", 32'(sof), 1);
  endtask

  initial begin
    int n;
    logic [2:0] bars [10];
    logic [2:0] bar_exp [10];
    logic [2:0] scr_exp [9];
    logic [3:0] p;
    bar_exp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
                3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    scr_exp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
                3'd2, 3'd1, 3'd0, 3'd7};

    #2 reset = 1;
    #1;
    chk("reset_outs", 32'(dut_obs()), 32'(RST_V));
    model_reset();
    repeat (3) clk_step();
    reset = 0;
    enable = 1;

    run_to_sof(10, n);
    chk("first_sof_clks", n, 2);
    run_to_sof(400, n);
    chk("frame_clks", n, 196);

    for (int i = 0; i < 400 && mv != 2; i++) clk_step();
    mode = 2'd2;
    run_to_sof(400, n);
    chk("checker_at_sof", 32'(rgb), 0);
    repeat (4) clk_step();
    chk("checker_x", 32'(pix_x), 2);
    chk("checker_x2", 32'(rgb), 7);

    mode = 2'd1;
    run_to_sof(400, n);
    bars[0] = rgb;
    for (int i = 1; i < 10; i++) begin
      repeat (2) clk_step();
      bars[i] = rgb;
    end
    for (int i = 0; i < 10; i++)
      chk($sformatf("bar_x%0d", i), 32'(bars[i]), 32'(bar_exp[i]));

    run_to_sof(400, n);
    repeat (5) clk_step();
    p = pix_x;
    chk("pre_hold_x", 32'(p), 2);
    enable = 0;
    repeat (5) begin
      clk_step();
      chk("hold_sof", 32'(sof), 0);
    end
    chk("hold_x", 32'(pix_x), 2);
    enable = 1;
    repeat (2) clk_step();
    chk("resume_x", 32'(pix_x), 3);

    for (int i = 0; i < 400 && !(mh == 5 && mv == 2); i++)
      clk_step();
    reset = 1;
    mode = 2'd3;
    #1;
    chk("midframe_reset", 32'(dut_obs()), 32'(RST_V));
    model_reset();
    repeat (2) clk_step();
    reset = 0;
    run_to_sof(10, n);
    chk("post_reset_clks", n, 2);
    chk("post_reset_x", 32'(pix_x), 0);
    chk("post_reset_y", 32'(pix_y), 0);

    chk("scroll_f0", 32'(rgb), 32'(scr_exp[0]));
    chk("frame0", 32'(frame_cnt), 0);
    for (int k = 1; k < 9; k++) begin
      run_to_sof(400, n);
      chk($sformatf("scroll_f%0d", k), 32'(rgb), 32'(scr_exp[k]));
    end
    for (int k = 9; k <= 256; k++) begin
      run_to_sof(400, n);
      if (k == 255) chk("frame255", 32'(frame_cnt), 255);
      if (k == 256) chk("frame_wrap", 32'(frame_cnt), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
